// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, control-word bit positions and microsteps.
package cpu_pkg;

  localparam int unsigned CTRL_W = 16;
  localparam int unsigned STEP_W = 3;
  localparam int unsigned OP_W   = 4;

  localparam logic [OP_W-1:0] OP_NOP = 4'b0000;
  localparam logic [OP_W-1:0] OP_LDA = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0011;
  localparam logic [OP_W-1:0] OP_STA = 4'b0100;
  localparam logic [OP_W-1:0] OP_LDI = 4'b0101;
  localparam logic [OP_W-1:0] OP_JMP = 4'b0110;
  localparam logic [OP_W-1:0] OP_JC  = 4'b0111;
  localparam logic [OP_W-1:0] OP_JZ  = 4'b1000;
  localparam logic [OP_W-1:0] OP_OUT = 4'b1110;
  localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

  localparam int unsigned CB_HLT = 15;
  localparam int unsigned CB_MI  = 14;
  localparam int unsigned CB_RI  = 13;
  localparam int unsigned CB_RO  = 12;
  localparam int unsigned CB_IO  = 11;
  localparam int unsigned CB_II  = 10;
  localparam int unsigned CB_AI  = 9;
  localparam int unsigned CB_AO  = 8;
  localparam int unsigned CB_EO  = 7;
  localparam int unsigned CB_SU  = 6;
  localparam int unsigned CB_BI  = 5;
  localparam int unsigned CB_OI  = 4;
  localparam int unsigned CB_CE  = 3;
  localparam int unsigned CB_CO  = 2;
  localparam int unsigned CB_J   = 1;
  localparam int unsigned CB_FI  = 0;

  localparam logic [STEP_W-1:0] T0 = 3'd0;
  localparam logic [STEP_W-1:0] T1 = 3'd1;
  localparam logic [STEP_W-1:0] T2 = 3'd2;
  localparam logic [STEP_W-1:0] T3 = 3'd3;
  localparam logic [STEP_W-1:0] T4 = 3'd4;

  // One-hot control word with only the given bit set.
  function automatic logic [CTRL_W-1:0] cbit(input int unsigned idx);
    return CTRL_W'(1) << idx;
  endfunction

endpackage

// File: rtl/control_rom.sv
// Microcode ROM: (step, opcode, flags) -> control word plus last-step marker.
module control_rom
  import cpu_pkg::*;
#(
  parameter bit HALT_ON_UNDEF = 1'b0
) (
  input  logic [2:0]  step,
  input  logic [3:0]  opcode,
  input  logic        cf,
  input  logic        zf,
  output logic [15:0] ctrl,
  output logic        last
);

  logic [OP_W-1:0] op_eff;

  // Fold the undefined opcodes 1001-1101 onto NOP or HLT.
  always_comb begin
    op_eff = opcode;
    if (opcode >= 4'd9 && opcode <= 4'd13) op_eff = HALT_ON_UNDEF ? OP_HLT : OP_NOP;
  end

  // Microinstruction decode; unused slots give word 0 and end the instruction.
  always_comb begin
    ctrl = '0;
    last = 1'b0;
    case (step)
      T0: ctrl = cbit(CB_CO) | cbit(CB_MI);
      T1: ctrl = cbit(CB_RO) | cbit(CB_II) | cbit(CB_CE);
      T2: begin
        last = 1'b1;
        case (op_eff)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ctrl = cbit(CB_IO) | cbit(CB_MI);
            last = 1'b0;
          end
          OP_LDI: ctrl = cbit(CB_IO) | cbit(CB_AI);
          OP_JMP: ctrl = cbit(CB_IO) | cbit(CB_J);
          OP_JC:  if (cf) ctrl = cbit(CB_IO) | cbit(CB_J);
          OP_JZ:  if (zf) ctrl = cbit(CB_IO) | cbit(CB_J);
          OP_OUT: ctrl = cbit(CB_AO) | cbit(CB_OI);
          OP_HLT: ctrl = cbit(CB_HLT);
          default: ctrl = '0;
        endcase
      end
      T3: begin
        last = 1'b1;
        case (op_eff)
          OP_LDA: ctrl = cbit(CB_RO) | cbit(CB_AI);
          OP_ADD, OP_SUB: begin
            ctrl = cbit(CB_RO) | cbit(CB_BI);
            last = 1'b0;
          end
          OP_STA: ctrl = cbit(CB_AO) | cbit(CB_RI);
          default: ctrl = '0;
        endcase
      end
      T4: begin
        last = 1'b1;
        case (op_eff)
          OP_ADD: ctrl = cbit(CB_EO) | cbit(CB_AI) | cbit(CB_FI);
          OP_SUB: ctrl = cbit(CB_EO) | cbit(CB_AI) | cbit(CB_SU) | cbit(CB_FI);
          default: ctrl = '0;
        endcase
      end
      default: last = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Microcoded sequencer: step counter and halt latch around the microcode ROM.
module control_unit
  import cpu_pkg::*;
#(
  parameter bit HALT_ON_UNDEF = 1'b0
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [3:0]  opcode,
  input  logic        cf,
  input  logic        zf,
  output logic [15:0] ctrl,
  output logic [2:0]  step,
  output logic        halted
);

  logic [CTRL_W-1:0] rom_ctrl;
  logic              rom_last;
  logic [STEP_W-1:0] step_n;
  logic              halted_n;

  control_rom #(.HALT_ON_UNDEF(HALT_ON_UNDEF)) u_rom (
    .step   (step),
    .opcode (opcode),
    .cf     (cf),
    .zf     (zf),
    .ctrl   (rom_ctrl),
    .last   (rom_last)
  );

  // Step and halt registers; clr aborts any instruction in flight.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      step   <= T0;
      halted <= 1'b0;
    end else begin
      step   <= step_n;
      halted <= halted_n;
    end
  end

  // Next step: freeze when halted, recover from illegal values, wrap after the last step.
  always_comb begin
    step_n   = step;
    halted_n = halted;
    if (!halted) begin
      if (step > T4) begin
        step_n = T0;
      end else if (rom_ctrl[CB_HLT]) begin
        halted_n = 1'b1;
      end else if (rom_last) begin
        step_n = T0;
      end else begin
        step_n = STEP_W'(step + 3'd1);
      end
    end
  end

  // Halted override: only the hlt line stays asserted, no bus driver.
  always_comb begin
    ctrl = rom_ctrl;
    if (halted) ctrl = cbit(CB_HLT);
  end

endmodule
